systolic_sequencer: RTL and testbench

- Controller that drives one `systolic` array instance (DATA_SIZE, SIZE) for a complete matrix job.
- Accepts unskewed weight rows and input rows from a host over valid/ready streams.
- Loads the weights with `set_w`, feeds input rows to `data_stream` with per-lane skew, then zero-flushes the array.
- Deskews `y_stream` into aligned result rows with a valid flag, and signals done.

---
 rtl/systolic_sequencer.sv | 204 ++++++++++++++++++++
 tb/tb_systolic_sequencer.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/systolic_sequencer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | systolic_sequencer: loads weights, feeds skewed input rows into a        |
// | systolic array and deskews its results into aligned, flagged rows.       |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+

module systolic_sequencer #(
   parameter int DATA_SIZE      = 4,
   parameter int SIZE           = 3,
   parameter int NUM_ROWS       = 3,
   parameter int RESULT_LATENCY = 5
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      start,
   output logic                      busy,
   output logic                      done,
   output logic                      underrun,
   input  logic [DATA_SIZE*SIZE-1:0] w_row,
   input  logic                      w_valid,
   output logic                      w_ready,
   input  logic [DATA_SIZE*SIZE-1:0] x_row,
   input  logic                      x_valid,
   output logic                      x_ready,
   output logic                      set_w,
   output logic [DATA_SIZE*SIZE-1:0] w_stream,
   output logic [DATA_SIZE*SIZE-1:0] data_stream,
   input  logic [DATA_SIZE*SIZE-1:0] y_stream,
   output logic [DATA_SIZE*SIZE-1:0] y_row,
   output logic                      y_valid
);

   localparam int ROW_W  = DATA_SIZE * SIZE;
   localparam int WCNT_W = $clog2(SIZE + 1);
   localparam int XCNT_W = $clog2(NUM_ROWS + 1);
   localparam logic [WCNT_W-1:0] W_LAST = WCNT_W'(SIZE - 1);
   localparam logic [XCNT_W-1:0] X_LAST = XCNT_W'(NUM_ROWS - 1);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_LOAD_W = 3'd1,
      S_STREAM = 3'd2,
      S_FLUSH  = 3'd3,
      S_DONE   = 3'd4
   } state_t;

   state_t                    state_q, state_d;
   logic [WCNT_W-1:0]         wcnt_q, wcnt_d;
   logic [XCNT_W-1:0]         xcnt_q, xcnt_d;
   logic                      underrun_q, underrun_d;
   logic                      set_w_q, set_w_d;
   logic [ROW_W-1:0]          w_stream_q, w_stream_d;
   logic [ROW_W-1:0]          data_stream_q, data_stream_d;
   logic [ROW_W-1:0]          y_row_q, y_row_d;
   logic [RESULT_LATENCY:0]   vpipe_q, vpipe_d;
   logic [SIZE-1:0]           occ_q, occ_d;

   logic                      x_hs;
   logic [ROW_W-1:0]          lane_in;
   logic [ROW_W-1:0]          skew_out;
   logic [ROW_W-1:0]          deskew_out;

   assign x_hs    = x_valid && (state_q == S_STREAM);
   assign lane_in = x_hs ? x_row : '0;

   // Lane c is delayed c cycles so the array sees a diagonal wavefront.
   for (genvar c = 0; c < SIZE; c++) begin : g_skew
      if (c == 0) begin : g_direct
         assign skew_out[ROW_W-1 -: DATA_SIZE] = lane_in[ROW_W-1 -: DATA_SIZE];
      end else begin : g_line
         logic [DATA_SIZE-1:0] line_q [c];
         logic [DATA_SIZE-1:0] line_d [c];
         always_comb begin
            line_d[0] = lane_in[(SIZE-c)*DATA_SIZE-1 -: DATA_SIZE];
            for (int s = 1; s < c; s++) line_d[s] = line_q[s-1];
         end
         always_ff @(posedge clk) begin
            if (reset) begin
               for (int s = 0; s < c; s++) line_q[s] <= '0;
            end else begin
               line_q <= line_d;
            end
         end
         assign skew_out[(SIZE-c)*DATA_SIZE-1 -: DATA_SIZE] = line_q[c-1];
      end
   end

   for (genvar j = 0; j < SIZE; j++) begin : g_deskew
      localparam int D = SIZE - 1 - j;
      if (D == 0) begin : g_direct
         assign deskew_out[(SIZE-j)*DATA_SIZE-1 -: DATA_SIZE] =
            y_stream[(SIZE-j)*DATA_SIZE-1 -: DATA_SIZE];
      end else begin : g_line
         logic [DATA_SIZE-1:0] line_q [D];
         logic [DATA_SIZE-1:0] line_d [D];
         always_comb begin
            line_d[0] = y_stream[(SIZE-j)*DATA_SIZE-1 -: DATA_SIZE];
            for (int s = 1; s < D; s++) line_d[s] = line_q[s-1];
         end
         always_ff @(posedge clk) begin
            if (reset) begin
               for (int s = 0; s < D; s++) line_q[s] <= '0;
            end else begin
               line_q <= line_d;
            end
         end
         assign deskew_out[(SIZE-j)*DATA_SIZE-1 -: DATA_SIZE] = line_q[D-1];
      end
   end

   always_comb begin
      state_d       = state_q;
      wcnt_d        = wcnt_q;
      xcnt_d        = xcnt_q;
      underrun_d    = underrun_q;
      set_w_d       = 1'b0;
      w_stream_d    = w_stream_q;
      data_stream_d = skew_out;
      // The valid pipe runs one stage ahead of y_row so the gate lines up with the flag.
      y_row_d       = vpipe_q[RESULT_LATENCY-1] ? deskew_out : '0;
      vpipe_d       = vpipe_q << 1;
      vpipe_d[0]    = x_hs;
      occ_d         = occ_q << 1;
      occ_d[0]      = x_hs;

      case (state_q)
         S_IDLE: begin
            w_stream_d = '0;
            if (start) begin
               state_d    = S_LOAD_W;
               wcnt_d     = '0;
               xcnt_d     = '0;
               underrun_d = 1'b0;
               vpipe_d    = '0;
            end
         end
         S_LOAD_W: begin
            if (w_valid) begin
               set_w_d    = 1'b1;
               w_stream_d = w_row;
               wcnt_d     = wcnt_q + WCNT_W'(1);
               if (wcnt_q == W_LAST) state_d = S_STREAM;
            end
         end
         S_STREAM: begin
            if (x_valid) begin
               xcnt_d = xcnt_q + XCNT_W'(1);
               if (xcnt_q == X_LAST) state_d = S_FLUSH;
            end else begin
               underrun_d = 1'b1;
            end
         end
         S_FLUSH: begin
            if (vpipe_q == '0 && occ_q == '0) state_d = S_DONE;
         end
         S_DONE: begin
            w_stream_d = '0;
            state_d    = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q       <= S_IDLE;
         wcnt_q        <= '0;
         xcnt_q        <= '0;
         underrun_q    <= 1'b0;
         set_w_q       <= 1'b0;
         w_stream_q    <= '0;
         data_stream_q <= '0;
         y_row_q       <= '0;
         vpipe_q       <= '0;
         occ_q         <= '0;
      end else begin
         state_q       <= state_d;
         wcnt_q        <= wcnt_d;
         xcnt_q        <= xcnt_d;
         underrun_q    <= underrun_d;
         set_w_q       <= set_w_d;
         w_stream_q    <= w_stream_d;
         data_stream_q <= data_stream_d;
         y_row_q       <= y_row_d;
         vpipe_q       <= vpipe_d;
         occ_q         <= occ_d;
      end
   end

   assign busy        = (state_q != S_IDLE);
   assign done        = (state_q == S_DONE);
   assign w_ready     = (state_q == S_LOAD_W);
   assign x_ready     = (state_q == S_STREAM);
   assign underrun    = underrun_q;
   assign set_w       = set_w_q;
   assign w_stream    = w_stream_q;
   assign data_stream = data_stream_q;
   assign y_row       = y_row_q;
   assign y_valid     = vpipe_q[RESULT_LATENCY];

endmodule

`default_nettype wire

// File: tb/tb_systolic_sequencer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_systolic_sequencer: directed self-checking bench for                  |
// | systolic_sequencer with a behavioural array returning lane j = j+1.      |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+

module tb_systolic_sequencer;

   localparam int DW = 4;
   localparam int N  = 3;
   localparam int W  = DW * N;

   logic         clk = 1'b0;
   logic         reset = 1'b1;
   logic         start = 1'b0;
   logic         w_valid = 1'b0;
   logic         x_valid = 1'b0;
   logic [W-1:0] w_row = '0;
   logic [W-1:0] x_row = '0;
   logic [W-1:0] y_stream;
   logic         busy, done, underrun, w_ready, x_ready, set_w, y_valid;
   logic [W-1:0] w_stream, data_stream, y_row;
   logic [6:0]   ctl;

   int n_checks = 0;
   int n_err    = 0;

   logic [6:0]   exp_ctl [20];
   logic [W-1:0] exp_ws  [20];
   logic [W-1:0] exp_ds  [20];
   logic [W-1:0] exp_y   [20];
   logic [W-1:0] rows    [3];
   logic [3:0]   hist = '0;

   systolic_sequencer #(
      .DATA_SIZE(DW), .SIZE(N), .NUM_ROWS(3), .RESULT_LATENCY(5)
   ) dut (
      .clk(clk), .reset(reset), .start(start), .busy(busy), .done(done),
      .underrun(underrun), .w_row(w_row), .w_valid(w_valid), .w_ready(w_ready),
      .x_row(x_row), .x_valid(x_valid), .x_ready(x_ready), .set_w(set_w),
      .w_stream(w_stream), .data_stream(data_stream), .y_stream(y_stream),
      .y_row(y_row), .y_valid(y_valid)
   );

   always #5 clk = ~clk;

   // Array model: a row whose lane 0 hit data_stream at T returns lane j = j+1 at T+2+j.
   always @(posedge clk) hist <= {hist[2:0], data_stream[W-1 -: DW] != '0};
   assign y_stream = {hist[1] ? 4'd1 : 4'd0, hist[2] ? 4'd2 : 4'd0, hist[3] ? 4'd3 : 4'd0};

   assign ctl = {busy, done, set_w, y_valid, w_ready, x_ready, underrun};

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      n_checks++;
      assert (obs === exp_v) else begin
         n_err++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp_v);
      end
   endtask

   task automatic clear_tab();
      for (int i = 0; i < 20; i++) begin
         exp_ctl[i] = '0;
         exp_ws[i]  = '0;
         exp_ds[i]  = '0;
         exp_y[i]   = '0;
      end
   endtask

   // Nominal: weights at 1..3, rows at 4..6, DONE at 14.
   task automatic load_t1();
      clear_tab();
      exp_ctl[1] = 7'b1000100; exp_ctl[2] = 7'b1010100; exp_ctl[3] = 7'b1010100;
      exp_ctl[4] = 7'b1010010; exp_ctl[5] = 7'b1000010; exp_ctl[6] = 7'b1000010;
      for (int i = 7; i <= 9; i++)   exp_ctl[i] = 7'b1000000;
      for (int i = 10; i <= 12; i++) exp_ctl[i] = 7'b1001000;
      exp_ctl[13] = 7'b1000000; exp_ctl[14] = 7'b1100000;
      exp_ws[2] = 12'h123; exp_ws[3] = 12'h456;
      for (int i = 4; i <= 14; i++)  exp_ws[i] = 12'h789;
      exp_ds[5] = 12'h100; exp_ds[6] = 12'h420; exp_ds[7] = 12'h753;
      exp_ds[8] = 12'h086; exp_ds[9] = 12'h009;
      for (int i = 10; i <= 12; i++) exp_y[i] = 12'h123;
   endtask

   // Weight stall: weights at 1,4,5, rows at 6..8, DONE at 16.
   task automatic load_t2();
      clear_tab();
      exp_ctl[1] = 7'b1000100; exp_ctl[2] = 7'b1010100; exp_ctl[3] = 7'b1000100;
      exp_ctl[4] = 7'b1000100; exp_ctl[5] = 7'b1010100; exp_ctl[6] = 7'b1010010;
      exp_ctl[7] = 7'b1000010; exp_ctl[8] = 7'b1000010;
      for (int i = 9; i <= 11; i++)  exp_ctl[i] = 7'b1000000;
      for (int i = 12; i <= 14; i++) exp_ctl[i] = 7'b1001000;
      exp_ctl[15] = 7'b1000000; exp_ctl[16] = 7'b1100000;
      for (int i = 2; i <= 4; i++)   exp_ws[i] = 12'h123;
      exp_ws[5] = 12'h456;
      for (int i = 6; i <= 16; i++)  exp_ws[i] = 12'h789;
      exp_ds[7] = 12'h100; exp_ds[8] = 12'h420; exp_ds[9] = 12'h753;
      exp_ds[10] = 12'h086; exp_ds[11] = 12'h009;
      for (int i = 12; i <= 14; i++) exp_y[i] = 12'h123;
   endtask

   // Underrun: rows at 4,6,7 with a gap at 5, DONE at 15.
   task automatic load_t3();
      clear_tab();
      exp_ctl[1] = 7'b1000100; exp_ctl[2] = 7'b1010100; exp_ctl[3] = 7'b1010100;
      exp_ctl[4] = 7'b1010010; exp_ctl[5] = 7'b1000010; exp_ctl[6] = 7'b1000011;
      exp_ctl[7] = 7'b1000011; exp_ctl[8] = 7'b1000001; exp_ctl[9] = 7'b1000001;
      exp_ctl[10] = 7'b1001001; exp_ctl[11] = 7'b1000001; exp_ctl[12] = 7'b1001001;
      exp_ctl[13] = 7'b1001001; exp_ctl[14] = 7'b1000001; exp_ctl[15] = 7'b1100001;
      exp_ctl[16] = 7'b0000001;
      exp_ws[2] = 12'h123; exp_ws[3] = 12'h456;
      for (int i = 4; i <= 15; i++)  exp_ws[i] = 12'h789;
      exp_ds[5] = 12'h100; exp_ds[6] = 12'h020; exp_ds[7] = 12'h403;
      exp_ds[8] = 12'h750; exp_ds[9] = 12'h086; exp_ds[10] = 12'h009;
      exp_y[10] = 12'h123; exp_y[12] = 12'h123; exp_y[13] = 12'h123;
   endtask

   task automatic run_job(input string tag, input int ncyc, input logic [19:0] wmask,
                          input logic [19:0] xmask, input bit hold_start, input int reset_at);
      int wi = 0;
      int xi = 0;
      for (int c = 0; c < ncyc; c++) begin
         start   = (c == 0) || (hold_start && c < ncyc - 1);
         reset   = (c == reset_at);
         w_valid = wmask[c];
         w_row   = wmask[c] ? rows[wi % 3] : 12'hFFF;
         if (wmask[c]) wi++;
         x_valid = xmask[c];
         x_row   = xmask[c] ? rows[xi % 3] : 12'hEEE;
         if (xmask[c]) xi++;
         chk($sformatf("%s c%0d ctl", tag, c), 32'(ctl), 32'(exp_ctl[c]));
         chk($sformatf("%s c%0d w_stream", tag, c), 32'(w_stream), 32'(exp_ws[c]));
         chk($sformatf("%s c%0d data_stream", tag, c), 32'(data_stream), 32'(exp_ds[c]));
         chk($sformatf("%s c%0d y_row", tag, c), 32'(y_row), 32'(exp_y[c]));
         step();
      end
      start   = 1'b0;
      reset   = 1'b0;
      w_valid = 1'b0;
      x_valid = 1'b0;
   endtask

   initial begin
      int seen;
      rows[0] = 12'h123;
      rows[1] = 12'h456;
      rows[2] = 12'h789;

      reset = 1'b1;
      step(); step(); step();
      chk("rst busy", 32'(busy), 32'd0);
      chk("rst done", 32'(done), 32'd0);
      chk("rst underrun", 32'(underrun), 32'd0);
      chk("rst set_w", 32'(set_w), 32'd0);
      chk("rst y_valid", 32'(y_valid), 32'd0);
      chk("rst w_ready", 32'(w_ready), 32'd0);
      chk("rst x_ready", 32'(x_ready), 32'd0);
      chk("rst w_stream", 32'(w_stream), 32'd0);
      chk("rst data_stream", 32'(data_stream), 32'd0);
      chk("rst y_row", 32'(y_row), 32'd0);
      reset = 1'b0;
      step();

      load_t1();
      run_job("skew", 16, 20'h001FE, 20'h00070, 1'b0, -1);

      load_t2();
      run_job("wstall", 18, 20'h00032, 20'h001C0, 1'b0, -1);

      load_t3();
      run_job("underrun", 17, 20'h0000E, 20'h000D0, 1'b0, -1);

      // Sticky underrun visible until the start is accepted; start held while busy.
      load_t1();
      exp_ctl[0] = 7'b0000001;
      run_job("busystart", 16, 20'h0000E, 20'h00070, 1'b1, -1);
      chk("busystart idle", 32'(busy), 32'd0);

      start = 1'b1;
      reset = 1'b1;
      step();
      start = 1'b0;
      reset = 1'b0;
      chk("startrst busy0", 32'(busy), 32'd0);
      step();
      chk("startrst busy1", 32'(busy), 32'd0);
      chk("startrst w_ready", 32'(w_ready), 32'd0);

      // Abort during STREAM: reset sampled with the third row offered.
      load_t1();
      run_job("abort", 7, 20'h0000E, 20'h00070, 1'b0, 6);
      chk("abort busy", 32'(busy), 32'd0);
      chk("abort data_stream", 32'(data_stream), 32'd0);
      chk("abort y_valid", 32'(y_valid), 32'd0);
      chk("abort done", 32'(done), 32'd0);
      chk("abort set_w", 32'(set_w), 32'd0);
      seen = 0;
      for (int i = 0; i < 20; i++) begin
         if (done || busy || y_valid) seen++;
         step();
      end
      chk("abort quiet", 32'(seen), 32'd0);

      load_t1();
      run_job("clean", 16, 20'h0000E, 20'h00070, 1'b0, -1);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
      $finish;
   end

endmodule

`default_nettype wire
